// File: rtl/uart_rx_v3.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_v3
// Brief    : UART receiver with configurable frame format (5-9 data bits,
//            optional parity, 1/2 stop bits), 3-sample mid-bit majority
//            voting, and a valid/ready output with sticky overrun.
// Revision : 1.0
// ============================================================================
module uart_rx_v3 #(
    parameter int CYCLES_PER_BIT = 87,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_EN      = 0,
    parameter int PARITY_ODD     = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_si,
    input  logic                 rx_ready,
    output logic                 rx_dv,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int                 c_CNT_W     = $clog2(CYCLES_PER_BIT);
    localparam int                 c_MID       = CYCLES_PER_BIT / 2;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_SMP_A     = c_CNT_W'(c_MID - 1);
    localparam logic [c_CNT_W-1:0] c_SMP_B     = c_CNT_W'(c_MID);
    localparam logic [c_CNT_W-1:0] c_DECIDE    = c_CNT_W'(c_MID + 1);
    localparam logic [3:0]         c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]         c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic               c_PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [1:0]           r_sync_vld;
    logic                 r_armed;
    state_t               r_state;
    state_t               w_state_nx;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_bit;
    logic                 r_smp_a;
    logic                 r_smp_b;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr;
    logic                 r_perr;

    logic w_rx_s;
    logic w_maj;
    logic w_decide;
    logic w_wrap;
    logic w_done;
    logic w_take;
    logic w_load;
    logic w_ferr_word;

    assign w_rx_s      = r_sync2;
    assign w_maj       = (r_smp_a & r_smp_b) | (r_smp_a & w_rx_s) | (r_smp_b & w_rx_s);
    assign w_decide    = (r_state != S_IDLE) && (r_cnt == c_DECIDE);
    assign w_wrap      = (r_state != S_IDLE) && (r_cnt == c_CNT_LAST);
    assign w_take      = rx_dv & rx_ready;
    assign w_load      = w_done & (~rx_dv | rx_ready);
    assign w_ferr_word = r_ferr | ~w_maj;

    // The reset value of the synchroniser is not a real line observation, so
    // arming waits until both stages hold sampled data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_sync_vld <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_sync1    <= rx_si;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            if (r_sync_vld[1] && r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_armed && !w_rx_s) begin
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (w_decide && w_maj) begin
                    w_state_nx = S_IDLE;
                end else if (w_wrap) begin
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (w_wrap && (r_bit == c_DATA_LAST)) begin
                    w_state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_wrap) begin
                    w_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                // Finish at the last decision point so a back-to-back start
                // edge is caught with no gap.
                if (w_decide && (r_bit == c_STOP_LAST)) begin
                    w_state_nx = S_IDLE;
                    w_done     = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_bit   <= 4'd0;
            r_smp_a <= 1'b1;
            r_smp_b <= 1'b1;
            r_shift <= '0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) || w_wrap || (w_state_nx != r_state)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_state_nx != r_state) begin
                r_bit <= 4'd0;
            end else if (w_wrap) begin
                r_bit <= r_bit + 4'd1;
            end
            if (r_cnt == c_SMP_A) begin
                r_smp_a <= w_rx_s;
            end
            if (r_cnt == c_SMP_B) begin
                r_smp_b <= w_rx_s;
            end
            if ((r_state == S_DATA) && w_decide) begin
                r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            end
            if (r_state == S_IDLE) begin
                r_ferr <= 1'b0;
                r_perr <= 1'b0;
            end
            if ((r_state == S_PARITY) && w_decide) begin
                r_perr <= ((^r_shift) ^ w_maj) != c_PAR_ODD;
            end
            if ((r_state == S_STOP) && w_decide && !w_maj) begin
                r_ferr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_dv         <= 1'b0;
            rx_byte       <= '0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (w_load) begin
                rx_dv         <= 1'b1;
                rx_byte       <= r_shift;
                rx_frame_err  <= w_ferr_word;
                rx_parity_err <= r_perr;
            end else if (w_take) begin
                rx_dv <= 1'b0;
            end
            if (w_done && !w_load) begin
                rx_overrun <= 1'b1;
            end else if (w_take) begin
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_v3.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_v3
// Brief    : Directed self-checking bench for uart_rx_v3 (8N1, 8E1, 7O2).
// Revision : 1.0
// ============================================================================
module tb_uart_rx_v3;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_line [3];
    logic       ready   [3];
    logic       dv      [3];
    logic       fe      [3];
    logic       pe      [3];
    logic       ov      [3];
    logic [7:0] byte_a;
    logic [7:0] byte_b;
    logic [6:0] byte_c;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         hi_cnt  [3];
    int         acc_cnt [3];
    int         acc_cyc [3];
    logic [8:0] acc_byte[3];
    logic       acc_fe  [3];
    logic       acc_pe  [3];

    uart_rx_v3 #(.CYCLES_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .rx_si(rx_line[0]), .rx_ready(ready[0]), .rx_dv(dv[0]),
        .rx_byte(byte_a), .rx_frame_err(fe[0]), .rx_parity_err(pe[0]), .rx_overrun(ov[0]));
    uart_rx_v3 #(.CYCLES_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .rx_si(rx_line[1]), .rx_ready(ready[1]), .rx_dv(dv[1]),
        .rx_byte(byte_b), .rx_frame_err(fe[1]), .rx_parity_err(pe[1]), .rx_overrun(ov[1]));
    uart_rx_v3 #(.CYCLES_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .rx_si(rx_line[2]), .rx_ready(ready[2]), .rx_dv(dv[2]),
        .rx_byte(byte_c), .rx_frame_err(fe[2]), .rx_parity_err(pe[2]), .rx_overrun(ov[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Records every high cycle of rx_dv and every accepted word per instance.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (dv[k] === 1'b1) begin
                hi_cnt[k]++;
                if (ready[k] === 1'b1) begin
                    acc_cnt[k]++;
                    acc_cyc[k] = cyc;
                    acc_fe[k]  = fe[k];
                    acc_pe[k]  = pe[k];
                    case (k)
                        0:       acc_byte[k] = {1'b0, byte_a};
                        1:       acc_byte[k] = {1'b0, byte_b};
                        default: acc_byte[k] = {2'b00, byte_c};
                    endcase
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input int which, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            rx_line[which] = v;
            tick();
        end
    endtask

    function automatic logic [31:0] frame(input logic [8:0] d, input int nd, input int pen,
                                          input logic pbit, input int ns, input logic sv);
        logic [31:0] f;
        int          p;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < nd; i++) f[1+i] = d[i];
        p = 1 + nd;
        if (pen != 0) begin
            f[p] = pbit;
            p++;
        end
        for (int i = 0; i < ns; i++) f[p+i] = sv;
        return f;
    endfunction

    // Drives one frame bit-serially; 'spike' inverts the line for one cycle at that offset.
    task automatic send(input int which, input logic [31:0] f, input int nbits, input int spike);
        for (int i = 0; i < nbits * CPB; i++) begin
            logic v;
            v = f[i / CPB];
            if (i == spike) v = ~v;
            rx_line[which] = v;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (dv[k] !== 1'b0) begin failures++; $display("FAIL reset_dv[%0d]: got %b want 0", k, dv[k]); end
            checks++; if (fe[k] !== 1'b0) begin failures++; $display("FAIL reset_fe[%0d]: got %b want 0", k, fe[k]); end
            checks++; if (pe[k] !== 1'b0) begin failures++; $display("FAIL reset_pe[%0d]: got %b want 0", k, pe[k]); end
            checks++; if (ov[k] !== 1'b0) begin failures++; $display("FAIL reset_ov[%0d]: got %b want 0", k, ov[k]); end
        end
        checks++; if (byte_a !== 8'h00) begin failures++; $display("FAIL reset_byte_a: got %h want 00", byte_a); end
        checks++; if (byte_b !== 8'h00) begin failures++; $display("FAIL reset_byte_b: got %h want 00", byte_b); end
        checks++; if (byte_c !== 7'h00) begin failures++; $display("FAIL reset_byte_c: got %h want 00", byte_c); end
        rst_n = 1'b1;
        hold(0, 1'b1, 10);
    endtask

    task automatic test_8n1_basic();
        int h0, a0, c0;
        h0 = hi_cnt[0]; a0 = acc_cnt[0]; c0 = cyc;
        send(0, frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1), 10, -1);
        hold(0, 1'b1, 20);
        checks++; if (acc_cnt[0] !== a0 + 1) begin failures++; $display("FAIL basic_count: got %0d want %0d", acc_cnt[0], a0 + 1); end
        checks++; if (hi_cnt[0] !== h0 + 1) begin failures++; $display("FAIL basic_pulse_len: got %0d want %0d", hi_cnt[0] - h0, 1); end
        checks++; if (acc_cyc[0] - c0 !== 157) begin failures++; $display("FAIL basic_latency: got %0d want 157", acc_cyc[0] - c0); end
        checks++; if (acc_byte[0] !== 9'h0A5) begin failures++; $display("FAIL basic_byte: got %h want 0a5", acc_byte[0]); end
        checks++; if (acc_fe[0] !== 1'b0) begin failures++; $display("FAIL basic_fe: got %b want 0", acc_fe[0]); end
        checks++; if (acc_pe[0] !== 1'b0) begin failures++; $display("FAIL basic_pe: got %b want 0", acc_pe[0]); end
        checks++; if (dv[0] !== 1'b0) begin failures++; $display("FAIL basic_dv_low: got %b want 0", dv[0]); end
    endtask

    task automatic test_parity();
        int c0;
        send(1, frame(9'h03C, 8, 1, 1'b1, 1, 1'b1), 11, -1);
        hold(1, 1'b1, 20);
        checks++; if (acc_byte[1] !== 9'h03C) begin failures++; $display("FAIL par_bad_byte: got %h want 03c", acc_byte[1]); end
        checks++; if (acc_pe[1] !== 1'b1) begin failures++; $display("FAIL par_bad_pe: got %b want 1", acc_pe[1]); end
        checks++; if (acc_fe[1] !== 1'b0) begin failures++; $display("FAIL par_bad_fe: got %b want 0", acc_fe[1]); end
        send(1, frame(9'h03C, 8, 1, 1'b0, 1, 1'b1), 11, -1);
        hold(1, 1'b1, 20);
        checks++; if (acc_pe[1] !== 1'b0) begin failures++; $display("FAIL par_good_pe: got %b want 0", acc_pe[1]); end
        c0 = cyc;
        send(2, frame(9'h055, 7, 1, 1'b1, 2, 1'b1), 11, -1);
        hold(2, 1'b1, 20);
        checks++; if (acc_byte[2] !== 9'h055) begin failures++; $display("FAIL 7o2_byte: got %h want 055", acc_byte[2]); end
        checks++; if (acc_pe[2] !== 1'b0) begin failures++; $display("FAIL 7o2_pe: got %b want 0", acc_pe[2]); end
        checks++; if (acc_fe[2] !== 1'b0) begin failures++; $display("FAIL 7o2_fe: got %b want 0", acc_fe[2]); end
        checks++; if (acc_cyc[2] - c0 !== 173) begin failures++; $display("FAIL 7o2_latency: got %0d want 173", acc_cyc[2] - c0); end
    endtask

    task automatic test_frame_err();
        int a0;
        a0 = acc_cnt[0];
        send(0, frame(9'h081, 8, 0, 1'b0, 1, 1'b0), 10, -1);
        hold(0, 1'b1, 30);
        checks++; if (acc_cnt[0] !== a0 + 1) begin failures++; $display("FAIL ferr_count: got %0d want %0d", acc_cnt[0], a0 + 1); end
        checks++; if (acc_byte[0] !== 9'h081) begin failures++; $display("FAIL ferr_byte: got %h want 081", acc_byte[0]); end
        checks++; if (acc_fe[0] !== 1'b1) begin failures++; $display("FAIL ferr_fe: got %b want 1", acc_fe[0]); end
        checks++; if (acc_pe[0] !== 1'b0) begin failures++; $display("FAIL ferr_pe: got %b want 0", acc_pe[0]); end
    endtask

    task automatic test_glitch();
        int h0, a0, c0;
        h0 = hi_cnt[0]; a0 = acc_cnt[0]; c0 = cyc;
        hold(0, 1'b0, 4);
        hold(0, 1'b1, 7);
        checks++; if (hi_cnt[0] !== h0) begin failures++; $display("FAIL glitch_no_dv: got %0d want %0d", hi_cnt[0], h0); end
        send(0, frame(9'h03C, 8, 0, 1'b0, 1, 1'b1), 10, -1);
        hold(0, 1'b1, 20);
        checks++; if (acc_cnt[0] !== a0 + 1) begin failures++; $display("FAIL glitch_count: got %0d want %0d", acc_cnt[0], a0 + 1); end
        checks++; if (acc_cyc[0] - c0 !== 168) begin failures++; $display("FAIL glitch_idle_return: got %0d want 168", acc_cyc[0] - c0); end
        checks++; if (acc_byte[0] !== 9'h03C) begin failures++; $display("FAIL glitch_byte: got %h want 03c", acc_byte[0]); end
    endtask

    task automatic test_spike();
        send(0, frame(9'h0F0, 8, 0, 1'b0, 1, 1'b1), 10, 73);
        hold(0, 1'b1, 20);
        checks++; if (acc_byte[0] !== 9'h0F0) begin failures++; $display("FAIL spike_byte: got %h want 0f0", acc_byte[0]); end
        checks++; if (acc_fe[0] !== 1'b0) begin failures++; $display("FAIL spike_fe: got %b want 0", acc_fe[0]); end
    endtask

    task automatic test_back_to_back_overrun();
        int a0;
        ready[0] = 1'b0;
        a0 = acc_cnt[0];
        send(0, frame(9'h011, 8, 0, 1'b0, 1, 1'b1), 10, -1);
        checks++; if (dv[0] !== 1'b1) begin failures++; $display("FAIL ovr_first_dv: got %b want 1", dv[0]); end
        checks++; if (ov[0] !== 1'b0) begin failures++; $display("FAIL ovr_first_ov: got %b want 0", ov[0]); end
        send(0, frame(9'h022, 8, 0, 1'b0, 1, 1'b1), 10, -1);
        hold(0, 1'b1, 10);
        checks++; if (dv[0] !== 1'b1) begin failures++; $display("FAIL ovr_hold_dv: got %b want 1", dv[0]); end
        checks++; if (byte_a !== 8'h11) begin failures++; $display("FAIL ovr_hold_byte: got %h want 11", byte_a); end
        checks++; if (ov[0] !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b want 1", ov[0]); end
        checks++; if (acc_cnt[0] !== a0) begin failures++; $display("FAIL ovr_no_accept: got %0d want %0d", acc_cnt[0], a0); end
        ready[0] = 1'b1;
        tick();
        checks++; if (dv[0] !== 1'b0) begin failures++; $display("FAIL ovr_accept_dv: got %b want 0", dv[0]); end
        checks++; if (ov[0] !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b want 0", ov[0]); end
        checks++; if (acc_byte[0] !== 9'h011) begin failures++; $display("FAIL ovr_accept_byte: got %h want 011", acc_byte[0]); end
        checks++; if (acc_cnt[0] !== a0 + 1) begin failures++; $display("FAIL ovr_accept_count: got %0d want %0d", acc_cnt[0], a0 + 1); end
        hold(0, 1'b1, 10);
    endtask

    task automatic test_reset_mid();
        int h0, a0;
        hold(0, 1'b0, 84);
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (byte_a !== 8'h00) begin failures++; $display("FAIL rstmid_byte: got %h want 00", byte_a); end
        checks++; if (dv[0] !== 1'b0) begin failures++; $display("FAIL rstmid_dv: got %b want 0", dv[0]); end
        checks++; if (fe[0] !== 1'b0 || pe[0] !== 1'b0 || ov[0] !== 1'b0) begin
            failures++; $display("FAIL rstmid_flags: got fe=%b pe=%b ov=%b want 0", fe[0], pe[0], ov[0]);
        end
        rst_n = 1'b1;
        h0 = hi_cnt[0];
        hold(0, 1'b0, 250);
        checks++; if (hi_cnt[0] !== h0) begin failures++; $display("FAIL rstmid_low_no_frame: got %0d want %0d", hi_cnt[0], h0); end
        checks++; if (dv[0] !== 1'b0) begin failures++; $display("FAIL rstmid_low_dv: got %b want 0", dv[0]); end
        hold(0, 1'b1, 10);
        a0 = acc_cnt[0];
        send(0, frame(9'h05A, 8, 0, 1'b0, 1, 1'b1), 10, -1);
        hold(0, 1'b1, 20);
        checks++; if (acc_cnt[0] !== a0 + 1) begin failures++; $display("FAIL rstmid_count: got %0d want %0d", acc_cnt[0], a0 + 1); end
        checks++; if (acc_byte[0] !== 9'h05A) begin failures++; $display("FAIL rstmid_byte_rx: got %h want 05a", acc_byte[0]); end
        checks++; if (acc_fe[0] !== 1'b0) begin failures++; $display("FAIL rstmid_fe: got %b want 0", acc_fe[0]); end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rx_line[k] = 1'b1;
            ready[k]   = 1'b1;
            hi_cnt[k]  = 0;
            acc_cnt[k] = 0;
            acc_cyc[k] = 0;
        end
        test_reset();
        test_8n1_basic();
        test_parity();
        test_frame_err();
        test_glitch();
        test_spike();
        test_back_to_back_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_v3.md
# uart_rx_v3

Parametrised UART receiver, successor to the fixed 8N1 receiver. It adds a configurable frame format (5–9 data bits, optional even/odd parity, 1 or 2 stop bits) and 3-sample majority voting at mid-bit. It reports framing and parity errors with each word and holds the word on a valid/ready output with overrun detection. It sits between the pad-side serial input and a byte-stream consumer, such as a FIFO or command parser.

## Interface
- `CYCLES_PER_BIT`, default 87: clock cycles per bit. Must be ≥ 8.
- `DATA_BITS`, default 8: data bits per frame, range 5–9, LSB first.
- `PARITY_EN`, default 0: when 1, a parity bit follows the data.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored if `PARITY_EN=0`.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `clk` in 1: single clock. All logic runs on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_si` in 1: asynchronous serial line. Idles high.
- `rx_ready` in 1: consumer accepts the word in any cycle where `rx_dv & rx_ready`.
- `rx_dv` out 1: a received word is valid. Held until accepted.
- `rx_byte` out `DATA_BITS`: received data, bit 0 = first data bit on the line.
- `rx_frame_err` out 1: a stop bit was sampled 0. Qualified by `rx_dv`.
- `rx_parity_err` out 1: parity mismatch. Qualified by `rx_dv`. Always 0 if `PARITY_EN=0`.
- `rx_overrun` out 1: sticky. A frame was discarded because the held word had not been accepted.

## Operation
- **Reset.** `rst_n` low asynchronously forces:
  - state IDLE, counters 0;
  - `rx_dv`, `rx_frame_err`, `rx_parity_err`, `rx_overrun` = 0; `rx_byte` = 0;
  - synchroniser flops = 1;
  - the arm flag cleared.
- **Reset mid-frame.** Abandons the frame. No partial word is ever presented.
- **Synchroniser.** `rx_si` passes through two flops to give `rx_si_s`. All decisions use `rx_si_s`.
- **Arming.** Start detection is armed only after `rx_si_s` has been seen high for at least 1 cycle since reset. A line held low out of reset produces no frames.
- **States:** IDLE → START → DATA → PARITY (only if `PARITY_EN`) → STOP → IDLE.
- **Bit counter.** `cnt` has width `$clog2(CYCLES_PER_BIT)` and counts 0..`CYCLES_PER_BIT-1`, then wraps to 0 and advances to the next bit. Define `MID = CYCLES_PER_BIT/2` (integer division).
- **Sampling.** `rx_si_s` is sampled at `cnt = MID-1`, `MID` and `MID+1`. The bit value is the majority of the three, decided at `cnt = MID+1`.
- **IDLE.** If armed and `rx_si_s == 0`, go to START with `cnt = 0`.
- **START.** If the majority at the decision point is 1, it is a false start: return to IDLE with no outputs changed. If it is 0, continue and enter DATA at the wrap.
- **DATA.** Shifts in `DATA_BITS` majority bits, LSB first, then moves to PARITY or STOP.
- **PARITY.** Error if the XOR of the data bits and the parity bit is not equal to `PARITY_ODD`.
- **STOP.** Samples `STOP_BITS` bits. Any stop bit decided as 0 sets the frame error for the word. The frame completes at the decision point of the last stop bit, and the FSM returns to IDLE in that same cycle without waiting out the bit. This allows the next start edge to be seen with zero gap.
- **Frame completion, `rx_dv` = 0, or `rx_dv` = 1 with `rx_ready` = 1 in that cycle:** the next cycle has `rx_dv = 1` with `rx_byte`, `rx_frame_err` and `rx_parity_err` loaded.
- **Frame completion, `rx_dv` = 1 with `rx_ready` = 0:** the new frame is discarded, the held word is unchanged, and `rx_overrun` is set.
- **Handshake.** `rx_dv & rx_ready` with no completing frame clears `rx_dv` next cycle. `rx_byte` and the error flags keep their last value.
- **Overrun clear.** `rx_overrun` clears on the cycle after any handshake, unless a new overrun occurs in that same cycle, in which case set wins.
- **Frame errors.** A word with a frame error is still delivered. A break condition is reported as a frame error with data 0; no separate break detection.

## Timing
- `t0` = first IDLE cycle with `rx_si_s` = 0. `rx_si_s` lags `rx_si` by 2 cycles.
- `cnt = k` of bit `j` (start bit is `j = 0`) occurs in cycle `t0 + 1 + j*CYCLES_PER_BIT + k`.
- `N = 1 + DATA_BITS + PARITY_EN + STOP_BITS`.
- `rx_dv` rises in cycle `t0 + (N-1)*CYCLES_PER_BIT + MID + 3`. Example: `CYCLES_PER_BIT=16`, 8N1 gives `t0 + 155`.
- False start returns to IDLE in cycle `t0 + MID + 3`.
- `rx_ready` is combinationally unused. All outputs are registered.

## Test plan
- `CYCLES_PER_BIT=16`, 8N1, send 0xA5, `rx_ready` = 1 → `rx_dv` pulses 1 cycle at `t0+155`, `rx_byte` = 0xA5, both error flags 0.
- 8E1, send 0x3C with parity bit 1 (wrong) → `rx_byte` = 0x3C, `rx_parity_err` = 1. Repeat with parity bit 0 → `rx_parity_err` = 0. 7O2, send 0x55 → `rx_byte` = 0x55, no errors.
- 8N1, send 0x81 with stop bit forced 0 → `rx_byte` = 0x81, `rx_frame_err` = 1. A 4-cycle low glitch on idle → no `rx_dv`, FSM back in IDLE at `t0+11`.
- Single-cycle inverted spike on `rx_si` at the mid-sample of data bit 3 of 0xF0 → `rx_byte` = 0xF0 (majority rejects the spike).
- `rx_ready` = 0, send 0x11 then 0x22 back-to-back with zero gap → `rx_dv` holds 0x11, `rx_overrun` = 1 after the second frame. Raise `rx_ready` → 0x11 accepted, `rx_overrun` = 0 next cycle.
- Assert `rst_n` low during data bit 4, hold `rx_si` low through release → all outputs 0, no frame until the line goes high. Then send 0x5A → received correctly.
